serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Parametrised, multi-bit-per-cycle serial adder/subtractor.
- Successor to the fixed 8-bit serial adder top.
- Adds width and digit-size generics, a subtract mode, busy/overflow status and start-while-busy protection.
- Sits behind a simple start/done command interface; operands are latched at start, and the result is held until the next accepted start.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  command request; sampled only in IDLE.
- sub  input  1  mode, latched with start: 0 = a+b, 1 = a-b.
- data_a  input  WIDTH  operand A, latched with start.
- data_b  input  WIDTH  operand B, latched with start.
- result  output  WIDTH+1  [WIDTH-1:0] sum/difference; [WIDTH] carry (add) or borrow (sub).
- overflow  output  1  two's-complement signed overflow of the last operation.
- busy  output  1  high from the edge that accepts start until done rises.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE; result, overflow, busy and done all 0; counters and carry cleared. Reset overrides start on the same edge and aborts any operation in progress; no done pulse for an aborted operation.
- Let N = WIDTH/BITS_PER_CYCLE.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: latch A=data_a, B = sub ? ~data_b : data_b; carry=sub; cnt=0; busy=1; go to SHIFT.
  - If start=0: stay in IDLE.
- SHIFT:
  - Each cycle, add the BITS_PER_CYCLE LSBs of A, B and carry via the ripple slice.
  - Shift the slice sum into the result shift register from the MSB side; shift A and B right by BITS_PER_CYCLE; update carry; cnt++.
  - After the Nth slice, go to DONE.
- DONE (one cycle):
  - result[WIDTH] = sub ? ~carry : carry.
  - overflow = carry-in XOR carry-out of the MSB bit position, which must be tracked inside the final slice.
  - done=1, busy=0; next state IDLE.
- Latency: done is high in the cycle after N+1 rising edges following the edge that sampled start. Example: WIDTH=8, BPC=1 gives 9 edges.
- result and overflow:
  - Updated only at DONE entry; stable otherwise. Intermediate shifting uses an internal register, never the result port.
  - Previous values are held through a new operation until its DONE.
- start while busy (SHIFT or DONE): ignored and not queued. A start held high through DONE is accepted in the next IDLE cycle (back-to-back operation, 1 idle cycle minimum).
- Width rules:
  - Add: result is the unsigned WIDTH+1 sum.
  - Sub: result[WIDTH-1:0] is a-b modulo 2^WIDTH; result[WIDTH]=1 iff a<b (unsigned).

Decomposition:
- Package serial_arith_pkg:
  - state enum type (IDLE, SHIFT, DONE).
  - mode constants MODE_ADD=0, MODE_SUB=1.
  - function for the count-register width, clog2(N)+1.
- Sub-module serial_addsub_slice:
  - Combinational BITS_PER_CYCLE-bit ripple adder.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, and msb_cin for overflow detection.
- Top module holds the FSM, counter and registers.

Test Plan:
- WIDTH=8, BPC=1: a=128, b=128, sub=0, 1-cycle start → done exactly 9 edges after start, result=9'h100, overflow=1, busy high for 9 cycles.
- WIDTH=8, BPC=1: a=5, b=7, sub=1 → result[7:0]=8'hFE, result[8]=1 (borrow), overflow=0. Then a=7, b=5, sub=1 → 9'h002.
- WIDTH=8: a=127, b=1, add → 9'h080, overflow=1; a=8'h80, b=1, sub → 9'h07F, overflow=1.
- WIDTH=16, BPC=4: a=16'hFFFF, b=1 → result=17'h10000 after 5 edges; then a=16'h1234, b=16'h4321 → 17'h05555.
- Pulse start with a different a/b mid-SHIFT → ignored, first result unchanged. Then assert rst for 1 cycle mid-operation → outputs all 0, no done; a fresh start afterwards completes correctly.
- Hold start=1 continuously → operations repeat every N+2 cycles, each producing exactly one done pulse.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the serial add/subtract datapath.
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   // The counter is one bit wider than clog2(N) so it can also hold N itself.
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational BITS_PER_CYCLE-bit ripple adder slice.
// msb_cin is the carry entering the top bit, which is needed for signed overflow.
module serial_addsub_slice #(
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic [BITS_PER_CYCLE-1:0] a,
   input  logic [BITS_PER_CYCLE-1:0] b,
   input  logic                      cin,
   output logic [BITS_PER_CYCLE-1:0] sum,
   output logic                      cout,
   output logic                      msb_cin
);

   logic [BITS_PER_CYCLE:0] w_c;

   assign w_c[0] = cin;

   // Full-adder chain, one bit per generate iteration.
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
      assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
   end

   assign cout    = w_c[BITS_PER_CYCLE];
   assign msb_cin = w_c[BITS_PER_CYCLE-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-bit-per-cycle serial adder/subtractor behind a start/done handshake.
// Subtraction is done as A + ~B + 1; the borrow is the inverted final carry.
module serial_addsub
   import serial_arith_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic [WIDTH:0]   result,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int N  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = cnt_width(N);

   // Reject configurations the shifter cannot handle.
   if (WIDTH < 2 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
      $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
   end

   state_t                    r_state;
   logic [WIDTH-1:0]          r_a;
   logic [WIDTH-1:0]          r_b;
   logic [WIDTH-1:0]          r_acc;
   logic                      r_carry;
   logic                      r_mode;
   logic                      r_msb_cin;
   logic [CW-1:0]             r_cnt;
   logic [WIDTH:0]            r_result;
   logic                      r_overflow;
   logic                      r_busy;
   logic                      r_done;

   logic [BITS_PER_CYCLE-1:0] w_sum;
   logic                      w_cout;
   logic                      w_msb_cin;
   logic [WIDTH+BITS_PER_CYCLE-1:0] w_acc_cat;
   logic [WIDTH-1:0]          w_acc_next;

   serial_addsub_slice #(
      .BITS_PER_CYCLE(BITS_PER_CYCLE)
   ) u_slice (
      .a       (r_a[BITS_PER_CYCLE-1:0]),
      .b       (r_b[BITS_PER_CYCLE-1:0]),
      .cin     (r_carry),
      .sum     (w_sum),
      .cout    (w_cout),
      .msb_cin (w_msb_cin)
   );

   // New slice enters from the MSB side; written this way so BPC == WIDTH also works.
   assign w_acc_cat  = {w_sum, r_acc} >> BITS_PER_CYCLE;
   assign w_acc_next = w_acc_cat[WIDTH-1:0];

   // Control FSM, datapath registers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_a        <= '0;
         r_b        <= '0;
         r_acc      <= '0;
         r_carry    <= 1'b0;
         r_mode     <= MODE_ADD;
         r_msb_cin  <= 1'b0;
         r_cnt      <= '0;
         r_result   <= '0;
         r_overflow <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_a     <= data_a;
                  r_b     <= (sub == MODE_SUB) ? ~data_b : data_b;
                  r_carry <= (sub == MODE_SUB);
                  r_mode  <= sub;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= SHIFT;
               end
            end
            SHIFT: begin
               r_acc   <= w_acc_next;
               r_a     <= r_a >> BITS_PER_CYCLE;
               r_b     <= r_b >> BITS_PER_CYCLE;
               r_carry <= w_cout;
               r_cnt   <= r_cnt + CW'(1);
               if (r_cnt == CW'(N - 1)) begin
                  // Only the final slice holds the true MSB position.
                  r_msb_cin <= w_msb_cin;
                  r_state   <= DONE;
               end
            end
            DONE: begin
               r_result   <= {((r_mode == MODE_SUB) ? ~r_carry : r_carry), r_acc};
               r_overflow <= r_msb_cin ^ r_carry;
               r_done     <= 1'b1;
               r_busy     <= 1'b0;
               r_state    <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign result   = r_result;
   assign overflow = r_overflow;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: directed corner cases plus random operands against an
// arithmetic reference model, on an 8-bit/1-bpc and a 16-bit/4-bpc instance.
module tb_serial_addsub;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [8:0]  res8;
   logic        ov8, busy8, done8;

   logic        start16 = 1'b0, sub16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [16:0] res16;
   logic        ov16, busy16, done16;

   int checks   = 0;
   int failures = 0;

   longint last8  = 0;
   longint last16 = 0;

   always #5 clk = ~clk;

   serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .sub(sub8),
      .data_a(a8), .data_b(b8),
      .result(res8), .overflow(ov8), .busy(busy8), .done(done8)
   );

   serial_addsub #(.WIDTH(16), .BITS_PER_CYCLE(4)) u_dut16 (
      .clk(clk), .rst(rst), .start(start16), .sub(sub16),
      .data_a(a16), .data_b(b16),
      .result(res16), .overflow(ov16), .busy(busy16), .done(done16)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views.
   function automatic void model(input int w, input longint ua, input longint ub,
                                 input bit s, output longint r, output bit ov);
      longint mask = (longint'(1) << w) - 1;
      longint half = longint'(1) << (w - 1);
      longint sa = (ua >= half) ? ua - (longint'(1) << w) : ua;
      longint sb = (ub >= half) ? ub - (longint'(1) << w) : ub;
      longint sr = s ? sa - sb : sa + sb;
      if (!s) r = ua + ub;
      else    r = ((ua - ub) & mask) | ((ua < ub) ? (longint'(1) << w) : 0);
      ov = (sr < -half) || (sr >= half);
   endfunction

   function automatic longint o_res(input bit wide);
      return wide ? longint'(res16) : longint'(res8);
   endfunction
   function automatic longint o_ov(input bit wide);
      return wide ? longint'(ov16) : longint'(ov8);
   endfunction
   function automatic longint o_busy(input bit wide);
      return wide ? longint'(busy16) : longint'(busy8);
   endfunction
   function automatic longint o_done(input bit wide);
      return wide ? longint'(done16) : longint'(done8);
   endfunction

   task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] b,
                         input bit s, input string tag);
      int     w = wide ? 16 : 8;
      int     n = wide ? 4 : 8;
      longint er, prev;
      bit     eov;
      int     k;
      model(w, wide ? longint'(a) : longint'(a[7:0]), wide ? longint'(b) : longint'(b[7:0]),
            s, er, eov);
      prev = wide ? last16 : last8;
      @(negedge clk);
      if (wide) begin a16 = a; b16 = b; sub16 = s; start16 = 1'b1; end
      else      begin a8 = a[7:0]; b8 = b[7:0]; sub8 = s; start8 = 1'b1; end
      @(posedge clk); #1;
      start8 = 1'b0; start16 = 1'b0;
      chk({tag, "_busy_start"}, o_busy(wide), 1);
      k = 0;
      while (k < 40) begin
         @(posedge clk); #1;
         k++;
         if (o_done(wide) == 1) break;
         if (k == 2) chk({tag, "_held"}, o_res(wide), prev);
      end
      chk({tag, "_latency"}, k, n + 1);
      chk({tag, "_result"}, o_res(wide), er);
      chk({tag, "_ovf"}, o_ov(wide), longint'(eov));
      chk({tag, "_busy_end"}, o_busy(wide), 0);
      if (wide) last16 = er; else last8 = er;
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, o_done(wide), 0);
   endtask

   initial begin
      int     k, pulses;
      longint er;
      bit     eov;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_res8", res8, 0);
      chk("rst_ov8", ov8, 0);
      chk("rst_busy8", busy8, 0);
      chk("rst_done8", done8, 0);
      chk("rst_res16", res16, 0);
      chk("rst_busy16", busy16, 0);
      @(negedge clk); rst = 1'b0;

      // Directed corner cases
      run_op(1'b0, 16'd128, 16'd128, 1'b0, "add_128_128");
      chk("add_128_128_abs", res8, 9'h100);
      run_op(1'b0, 16'd5, 16'd7, 1'b1, "sub_5_7");
      chk("sub_5_7_abs", res8, 9'h1FE);
      run_op(1'b0, 16'd7, 16'd5, 1'b1, "sub_7_5");
      chk("sub_7_5_abs", res8, 9'h002);
      run_op(1'b0, 16'd127, 16'd1, 1'b0, "add_127_1");
      chk("add_127_1_ovf_abs", ov8, 1);
      run_op(1'b0, 16'h80, 16'd1, 1'b1, "sub_80_1");
      chk("sub_80_1_abs", res8, 9'h07F);
      run_op(1'b1, 16'hFFFF, 16'd1, 1'b0, "w16_ffff_1");
      chk("w16_ffff_1_abs", res16, 17'h10000);
      run_op(1'b1, 16'h1234, 16'h4321, 1'b0, "w16_1234_4321");
      chk("w16_1234_4321_abs", res16, 17'h05555);

      // Random operands
      for (int i = 0; i < 16; i++)
         run_op(1'b0, 16'($urandom_range(0, 255)), 16'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), "rnd8");
      for (int i = 0; i < 10; i++)
         run_op(1'b1, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), "rnd16");

      // Start pulse while busy must be ignored and not queued
      @(negedge clk); a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); a8 = 8'd99; b8 = 8'd55; sub8 = 1'b1; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      k = 0;
      while (k < 40) begin
         @(posedge clk); #1; k++;
         if (done8) break;
      end
      chk("busy_start_latency", k, 5);
      chk("busy_start_result", res8, 30);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8) pulses++;
      end
      chk("busy_start_not_queued", pulses, 0);
      chk("busy_start_idle", busy8, 0);

      // Reset mid-operation aborts with no done pulse
      @(negedge clk); a8 = 8'd200; b8 = 8'd100; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk); #1; start8 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_res", res8, 0);
      chk("midrst_ov", ov8, 0);
      chk("midrst_busy", busy8, 0);
      chk("midrst_done", done8, 0);
      @(negedge clk); rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8) pulses++;
      end
      chk("midrst_no_done", pulses, 0);
      last8 = 0; last16 = 0;
      run_op(1'b0, 16'd200, 16'd100, 1'b0, "after_rst");

      // Start held high: one operation every N+2 cycles, one done each
      model(8, 3, 4, 1'b0, er, eov);
      @(negedge clk); a8 = 8'd3; b8 = 8'd4; sub8 = 1'b0; start8 = 1'b1;
      pulses = 0;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (done8) begin
            pulses++;
            chk("hold_period", i % 10, 0);
            chk("hold_result", res8, er);
         end
      end
      start8 = 1'b0;
      chk("hold_pulses", pulses, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
